// File: rtl/pl_mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package pl_mdu_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  function automatic logic op_is_mul(input logic [2:0] f);
    return ~f[2];
  endfunction

  function automatic logic a_is_signed(input logic [2:0] f);
    return f[2] ? ~f[0] : (f != OP_MULHU);
  endfunction

  // mulhsu and mulhu treat rs2 as unsigned; divu/remu treat both as unsigned
  function automatic logic b_is_signed(input logic [2:0] f);
    return f[2] ? ~f[0] : ~f[1];
  endfunction

endpackage

// File: rtl/pl_mdu_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
module pl_mdu_step
  import pl_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN:0]   hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // hi holds the partial product high word (mul) or the running remainder (div)
  always_comb begin
    sum     = hi + (lo[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    shifted = {hi[XLEN-1:0], lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, m};
    if (is_div) begin
      hi_next = diff[XLEN+1] ? shifted : diff[XLEN:0];
      lo_next = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      hi_next = {1'b0, sum[XLEN:1]};
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/pl_mdu_ctrl.sv
// RV32M multiply/divide sequencer: FSM, counter, operand registers, sign fix, result select.
// Optional MDU_FASTZERO_EN: zero-operand multiplies and divide-by-zero finish in one cycle.
module pl_mdu_ctrl
  import pl_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              neg_res;
  logic [XLEN:0]     hi, hi_next;
  logic [XLEN-1:0]   lo, lo_next, m;

  logic              is_mul, a_neg, b_neg, b_zero, neg_start;
  logic [XLEN-1:0]   a_mag, b_mag, quo_fix, rem_fix, fix_result;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign is_mul    = op_is_mul(func3);
  assign a_neg     = a_is_signed(func3) & a[XLEN-1];
  assign b_neg     = b_is_signed(func3) & b[XLEN-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign b_zero    = (b == '0);
  // remainder follows the dividend; a zero divisor leaves the all-ones quotient unsigned
  assign neg_start = is_mul   ? (a_neg ^ b_neg) :
                     func3[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);

`ifdef MDU_FASTZERO_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;
  assign fast_hit    = is_mul ? ((a == '0) | b_zero) : b_zero;
  assign fast_result = is_mul ? '0 : (func3[1] ? a : '1);
`endif

  pl_mdu_step #(.XLEN(XLEN)) u_step (
    .is_div  (op[2]),
    .hi      (hi),
    .lo      (lo),
    .m       (m),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  assign stall = ((state == IDLE) & start & ~flush) | (state == CALC) | (state == FIX);

  always_comb begin
    prod     = {hi[XLEN-1:0], lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -lo : lo;
    rem_fix  = neg_res ? -hi[XLEN-1:0] : hi[XLEN-1:0];
    case (op)
      OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MDU_FASTZERO_EN
          state_n = fast_hit ? DONE : CALC;
`else
          state_n = CALC;
`endif
        end
      end
      CALC:    if (cnt == CNT_W'(ITER - 1)) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Operands are latched as magnitudes; the step module never sees signs
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      neg_res <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      m       <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_n;
      done  <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op      <= func3;
            neg_res <= neg_start;
            hi      <= '0;
            lo      <= is_mul ? b_mag : a_mag;
            m       <= is_mul ? a_mag : b_mag;
            cnt     <= '0;
`ifdef MDU_FASTZERO_EN
            if (fast_hit) result <= fast_result;
`endif
          end
        end
        CALC: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: if (!flush) result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_mdu_ctrl.sv
// Directed bench for pl_mdu_ctrl with a result scoreboard and latency/stall checks.
module tb_pl_mdu_ctrl;
  import pl_mdu_pkg::*;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    string       tag;
  } exp_t;

  exp_t   sb[$];
  int     checks;
  int     errors;
  int     done_pulses;
  longint done_time;

`ifdef MDU_FASTZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif
  localparam int FULL = 34;

  pl_mdu_ctrl #(.XLEN(32)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .start  (start),
    .func3  (func3),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called one time unit after a rising edge while the DUT is idle; returns just after the start edge
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] exp_res, input string tag,
                               input bit scored, input bit hold);
    exp_t e;
    func3 = f;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (scored) begin
      e.res = exp_res;
      e.tag = tag;
      sb.push_back(e);
    end
    #1;
    checkOutput({tag, "_stall_start"}, {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic waitForDone(input int exp_lat);
    int   lat;
    int   stall_cycles;
    exp_t e;
    lat          = 1;
    stall_cycles = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (stall === 1'b1) stall_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    start     = 1'b0;
    done_time = $time;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=done expected=queued_op");
    end else begin
      e = sb.pop_front();
      checkOutput({e.tag, "_result"}, result, e.res);
      checkOutput({e.tag, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({e.tag, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_lat));
      checkOutput({e.tag, "_stall_in_done"}, {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      checkOutput({e.tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    int     pulses_before;
    longint t_first;
    checks      = 0;
    errors      = 0;
    done_pulses = 0;
    clrn  = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    func3 = 3'b000;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_stall", {31'b0, stall}, 32'd0);
    clrn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] start and flush together in IDLE");
    func3 = OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    checkOutput("idle_flush_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("idle_flush_stays_idle", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;

    $display("[TB] multiply ops");
    applyStimulus(OP_MUL,    32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, "mul",    1, 0); waitForDone(FULL);
    applyStimulus(OP_MULH,   32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, "mulh",   1, 0); waitForDone(FULL);
    applyStimulus(OP_MULHU,  32'hFFFFFFFE, 32'd3, 32'h00000002, "mulhu",  1, 0); waitForDone(FULL);
    applyStimulus(OP_MULHSU, 32'd3, 32'hFFFFFFFE, 32'h00000002, "mulhsu", 1, 0); waitForDone(FULL);
    applyStimulus(OP_MUL,    32'd0, 32'h12345678, 32'h00000000, "mul_zero", 1, 0); waitForDone(ZLAT);

    $display("[TB] divide ops");
    applyStimulus(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div",  1, 0); waitForDone(FULL);
    applyStimulus(OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem",  1, 0); waitForDone(FULL);
    applyStimulus(OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "divu", 1, 0); waitForDone(FULL);
    applyStimulus(OP_REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, "remu", 1, 0); waitForDone(FULL);
    applyStimulus(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_pos_neg", 1, 0); waitForDone(FULL);
    applyStimulus(OP_REM,  32'd7, 32'hFFFFFFFE, 32'h00000001, "rem_pos_neg", 1, 0); waitForDone(FULL);

    $display("[TB] overflow and divide by zero");
    applyStimulus(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf", 1, 0); waitForDone(FULL);
    applyStimulus(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf", 1, 0); waitForDone(FULL);
    applyStimulus(OP_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_by_zero", 1, 0); waitForDone(ZLAT);
    applyStimulus(OP_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_by_zero", 1, 0); waitForDone(ZLAT);
    applyStimulus(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by_zero", 1, 0); waitForDone(ZLAT);
    applyStimulus(OP_REMU, 32'd5, 32'd0, 32'h00000005, "remu_by_zero", 1, 0); waitForDone(ZLAT);

    $display("[TB] flush in the 10th CALC cycle");
    pulses_before = done_pulses;
    applyStimulus(OP_MUL, 32'd3, 32'd5, 32'd15, "flushed", 0, 0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checkOutput("flush_stall_low", {31'b0, stall}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    checkOutput("flush_no_done", 32'(done_pulses), 32'(pulses_before));
    checkOutput("flush_result_kept", result, 32'h00000005);
    applyStimulus(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "after_flush", 1, 0);
    waitForDone(FULL);

    $display("[TB] reset in the middle of CALC");
    pulses_before = done_pulses;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, "reset_mid", 0, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    clrn = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    checkOutput("midreset_result", result, 32'h0);
    checkOutput("midreset_done", {31'b0, done}, 32'd0);
    checkOutput("midreset_stall", {31'b0, stall}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end
    checkOutput("midreset_no_done", 32'(done_pulses), 32'(pulses_before));

    $display("[TB] start held through CALC, then back-to-back");
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, "held_start", 1, 1);
    waitForDone(FULL);
    t_first = done_time;
    applyStimulus(OP_REMU, 32'd100, 32'd7, 32'd2, "back_to_back", 1, 0);
    waitForDone(FULL);
    checkOutput("b2b_done_gap", 32'(done_time - t_first), 32'd350);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
